// File: rtl/instruction_fetch.sv
// PC generator and 2-entry fetch buffer in front of a synchronous-read imem.
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating pop/stall counters.
//
// state | meaning
// BOOT  | first cycle after reset release, no fetch issued unless redirected
// RUN   | steady fetch, issue whenever the buffer has a free credit
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_1000,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_1000,
    parameter int          ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_address,
    input  logic [31:0]           imem_data_out,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [31:0]           out_pc,
    output logic                  out_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    localparam int WIN_LSB = ADDR_WIDTH + 2;

    typedef enum logic {BOOT, RUN} state_t;

    typedef struct packed {
        logic        fault;
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic        inflight_q;
    logic [1:0]  count_q;
    entry_t      fifo_q [2];

    logic [31:0] next_pc;
    logic [2:0]  occ;
    logic        pop;
    logic        push;
    logic        issue;
    entry_t      cap;

    assign next_pc      = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : pc_q;
    assign imem_address = next_pc[WIN_LSB-1:2];

    assign out_valid = (count_q != 2'd0) && !redirect_valid;
    assign out_instr = fifo_q[0].instr;
    assign out_pc    = fifo_q[0].pc;
    assign out_fault = fifo_q[0].fault;

    assign pop  = out_valid && out_ready;
    assign push = inflight_q && !redirect_valid;
    assign occ  = {1'b0, count_q} + {2'b00, inflight_q};

    always_comb begin
        cap.fault = (req_pc_q[31:WIN_LSB] != IMEM_BASE[31:WIN_LSB]);
        cap.pc    = req_pc_q;
        cap.instr = cap.fault ? 32'h0 : imem_data_out;
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        if (state_q == BOOT)
            state_d = RUN;
        // A redirect flushes buffer and in-flight read, so it always has a credit.
        if (redirect_valid)
            issue = 1'b1;
        else if (state_q == RUN && occ < (3'd2 + {2'b00, pop}))
            issue = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (issue) begin
                req_pc_q <= next_pc;
                pc_q     <= next_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            for (int i = 0; i < 2; i++)
                fifo_q[i] <= '0;
        end else if (redirect_valid) begin
            count_q <= 2'd0;
        end else if (push && pop) begin
            if (count_q == 2'd2) begin
                fifo_q[0] <= fifo_q[1];
                fifo_q[1] <= cap;
            end else begin
                fifo_q[0] <= cap;
            end
        end else if (push) begin
            fifo_q[count_q[0]] <= cap;
            count_q            <= count_q + 2'd1;
        end else if (pop) begin
            // Head holds its last value when the buffer drains.
            if (count_q == 2'd2)
                fifo_q[0] <= fifo_q[1];
            count_q <= count_q - 2'd1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (pop && perf_fetch_cnt != 32'hFFFF_FFFF)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (out_valid && !out_ready && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
